// File: rtl/lsu_ctrl_pkg.sv
// Shared types for the load/store controller: op and state encodings,
// the captured access descriptor and small op-class helpers.
package lsu_ctrl_pkg;

    typedef enum logic [2:0] {
        OP_LW  = 3'd0,
        OP_LH  = 3'd1,
        OP_LHU = 3'd2,
        OP_LB  = 3'd3,
        OP_LBU = 3'd4,
        OP_SW  = 3'd5,
        OP_SH  = 3'd6,
        OP_SB  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } state_e;

    // Access descriptor latched when a request is accepted.
    typedef struct packed {
        op_e        op;
        logic [1:0] off;
    } acc_t;

    function automatic logic is_load(input op_e op);
        return (op == OP_LW) || (op == OP_LH) || (op == OP_LHU) ||
               (op == OP_LB) || (op == OP_LBU);
    endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// CPU-side request/response and DM-side signals of the load/store controller.
// master drives requests and returns DM read data; slave is the controller.
interface lsu_ctrl_if;
    import lsu_ctrl_pkg::*;

    logic        req;
    op_e         op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] rdata;
    logic        addr_err;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_memwr;
    logic [31:0] dm_rdata;

    modport master (
        output req, op, addr, wdata, dm_rdata,
        input  busy, done, rdata, addr_err, dm_addr, dm_wdata, dm_memwr
    );

    modport slave (
        input  req, op, addr, wdata, dm_rdata,
        output busy, done, rdata, addr_err, dm_addr, dm_wdata, dm_memwr
    );

endinterface

// File: rtl/lsu_ctrl_lane.sv
// Big-endian lane logic: load extraction/extension, sub-word store merge, alignment check.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs.
module lsu_lane
    import lsu_ctrl_pkg::*;
(
    input  op_e         op,
    input  logic [1:0]  offset,
    input  logic [31:0] dm_rdata,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word,
    output logic        misalign
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Offset 0 is the most significant byte of the word.
    always_comb begin
        byte_sel = dm_rdata[31:24];
        case (offset)
            2'd0: byte_sel = dm_rdata[31:24];
            2'd1: byte_sel = dm_rdata[23:16];
            2'd2: byte_sel = dm_rdata[15:8];
            2'd3: byte_sel = dm_rdata[7:0];
            default: byte_sel = dm_rdata[31:24];
        endcase
        half_sel = offset[1] ? dm_rdata[15:0] : dm_rdata[31:16];
    end

    always_comb begin
        load_data = dm_rdata;
        case (op)
            OP_LH:   load_data = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  load_data = {16'h0000, half_sel};
            OP_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  load_data = {24'h000000, byte_sel};
            default: load_data = dm_rdata;
        endcase
    end

    always_comb begin
        store_word = wdata;
        case (op)
            OP_SH: store_word = offset[1] ? {dm_rdata[31:16], wdata[15:0]}
                                          : {wdata[15:0], dm_rdata[15:0]};
            OP_SB: begin
                case (offset)
                    2'd0: store_word = {wdata[7:0], dm_rdata[23:0]};
                    2'd1: store_word = {dm_rdata[31:24], wdata[7:0], dm_rdata[15:0]};
                    2'd2: store_word = {dm_rdata[31:16], wdata[7:0], dm_rdata[7:0]};
                    2'd3: store_word = {dm_rdata[31:8], wdata[7:0]};
                    default: store_word = wdata;
                endcase
            end
            default: store_word = wdata;
        endcase
    end

    always_comb begin
        misalign = 1'b0;
        case (op)
            OP_LW, OP_SW:         misalign = (offset != 2'd0);
            OP_LH, OP_LHU, OP_SH: misalign = offset[0];
            default:              misalign = 1'b0;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller: turns CPU byte/half/word accesses into DM word reads/writes.
// Latency: done at N+1 (misaligned), N+2 (loads, SW), N+3 (SH/SB read-modify-write).
// Backpressure: busy high outside IDLE; requests seen while busy are dropped, not queued.
module lsu_ctrl
    import lsu_ctrl_pkg::*;
#(
    parameter int ADDR_BITS = 10
) (
    input  logic        clk,
    input  logic        rst,
    lsu_ctrl_if.slave   bus
);

    state_e      state;
    state_e      state_n;
    acc_t        acc_q;
    logic        err_q;
    logic [31:0] dm_addr_q;
    logic [31:0] dm_wdata_q;
    logic [31:0] rdata_q;

    op_e         sel_op;
    logic [1:0]  sel_off;
    logic [31:0] load_data;
    logic [31:0] store_word;
    logic        misalign;

    // In IDLE the lane block judges the incoming request; afterwards the latched one.
    assign sel_op  = (state == IDLE) ? bus.op         : acc_q.op;
    assign sel_off = (state == IDLE) ? bus.addr[1:0]  : acc_q.off;

    lsu_lane u_lane (
        .op         (sel_op),
        .offset     (sel_off),
        .dm_rdata   (bus.dm_rdata),
        .wdata      (dm_wdata_q),
        .load_data  (load_data),
        .store_word (store_word),
        .misalign   (misalign)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n      = state;
        bus.busy     = 1'b1;
        bus.done     = 1'b0;
        bus.addr_err = 1'b0;
        bus.dm_memwr = 1'b0;
        case (state)
            IDLE: begin
                bus.busy = 1'b0;
                if (bus.req) begin
                    if (misalign)             state_n = RESP;
                    else if (bus.op == OP_SW) state_n = WR;
                    else                      state_n = RD;
                end
            end
            RD:   state_n = is_load(acc_q.op) ? RESP : WR;
            WR: begin
                bus.dm_memwr = 1'b1;
                state_n      = RESP;
            end
            RESP: begin
                bus.done     = 1'b1;
                bus.addr_err = err_q;
                state_n      = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Upper address bits pass through untouched; DM simply aliases them.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q      <= '0;
            err_q      <= 1'b0;
            dm_addr_q  <= '0;
            dm_wdata_q <= '0;
            rdata_q    <= '0;
        end else begin
            if (state == IDLE && bus.req) begin
                acc_q.op   <= bus.op;
                acc_q.off  <= bus.addr[1:0];
                err_q      <= misalign;
                dm_addr_q  <= {bus.addr[31:ADDR_BITS], bus.addr[ADDR_BITS-1:2], 2'b00};
                dm_wdata_q <= bus.wdata;
            end
            // dm_wdata_q holds the raw store data until the merge overwrites it.
            if (state == RD) begin
                if (is_load(acc_q.op)) rdata_q    <= load_data;
                else                   dm_wdata_q <= store_word;
            end
        end
    end

    assign bus.rdata    = rdata_q;
    assign bus.dm_addr  = dm_addr_q;
    assign bus.dm_wdata = dm_wdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
module tb_lsu_ctrl;
    import lsu_ctrl_pkg::*;

    logic clk;
    logic rst;
    logic dm_clear;
    int   checks;
    int   failures;

    lsu_ctrl_if bus ();

    lsu_ctrl #(.ADDR_BITS(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word-wide DM, reads and writes on the negedge.
    logic [31:0] mem [256];
    always @(negedge clk) begin
        if (dm_clear) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
        end else if (bus.dm_memwr) begin
            mem[bus.dm_addr[9:2]] <= bus.dm_wdata;
        end
        bus.dm_rdata <= mem[bus.dm_addr[9:2]];
    end

    // Observations of the last issued request, cycles N+1..N+6.
    int          done_cyc;
    int          n_done;
    logic        err_at_done;
    logic [5:0]  memwr_mask;
    logic [5:0]  busy_mask;
    logic [31:0] dm_addr_c1;

    task automatic issue(input op_e o, input logic [31:0] a, input logic [31:0] d, input int extra);
        bus.req = 1'b1; bus.op = o; bus.addr = a; bus.wdata = d;
        done_cyc = 0; n_done = 0; err_at_done = 1'b0;
        memwr_mask = '0; busy_mask = '0; dm_addr_c1 = '0;
        @(posedge clk); #1;
        bus.req = (extra >= 1);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (bus.done) begin
                n_done++;
                if (done_cyc == 0) done_cyc = c;
                err_at_done = bus.addr_err;
            end
            memwr_mask[c-1] = bus.dm_memwr;
            busy_mask[c-1]  = bus.busy;
            if (c == 1) dm_addr_c1 = bus.dm_addr;
            @(posedge clk); #1;
            bus.req = (c + 1 <= extra);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; dm_clear = 1'b1;
        bus.req = 1'b0; bus.op = OP_LW; bus.addr = '0; bus.wdata = '0;
        repeat (3) @(posedge clk);
        #1; rst = 1'b0; dm_clear = 1'b0;
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.done); end
        checks++; if (bus.addr_err !== 1'b0) begin failures++; $display("FAIL reset_addr_err got=%b exp=0", bus.addr_err); end
        checks++; if (bus.dm_memwr !== 1'b0) begin failures++; $display("FAIL reset_memwr got=%b exp=0", bus.dm_memwr); end
        checks++; if (bus.rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", bus.rdata); end
        checks++; if (bus.dm_addr !== 32'h0) begin failures++; $display("FAIL reset_dm_addr got=%h exp=0", bus.dm_addr); end
        checks++; if (bus.dm_wdata !== 32'h0) begin failures++; $display("FAIL reset_dm_wdata got=%h exp=0", bus.dm_wdata); end
        @(posedge clk); #1;
    endtask

    task automatic test_word();
        issue(OP_SW, 32'h10, 32'h11223344, 0);
        checks++; if (done_cyc !== 2 || n_done !== 1) begin failures++; $display("FAIL sw_done got=%0d/%0d exp=2/1", done_cyc, n_done); end
        checks++; if (memwr_mask !== 6'b000001) begin failures++; $display("FAIL sw_memwr got=%b exp=000001", memwr_mask); end
        checks++; if (busy_mask !== 6'b000011) begin failures++; $display("FAIL sw_busy got=%b exp=000011", busy_mask); end
        checks++; if (err_at_done !== 1'b0) begin failures++; $display("FAIL sw_err got=%b exp=0", err_at_done); end
        checks++; if (mem[4] !== 32'h11223344) begin failures++; $display("FAIL sw_mem got=%h exp=11223344", mem[4]); end
        issue(OP_LW, 32'h10, 32'h0, 0);
        checks++; if (done_cyc !== 2 || n_done !== 1) begin failures++; $display("FAIL lw_done got=%0d/%0d exp=2/1", done_cyc, n_done); end
        checks++; if (bus.rdata !== 32'h11223344) begin failures++; $display("FAIL lw_rdata got=%h exp=11223344", bus.rdata); end
        checks++; if (memwr_mask !== 6'b000000) begin failures++; $display("FAIL lw_memwr got=%b exp=000000", memwr_mask); end
        checks++; if (dm_addr_c1 !== 32'h10) begin failures++; $display("FAIL lw_dm_addr got=%h exp=00000010", dm_addr_c1); end
    endtask

    task automatic test_byte();
        issue(OP_SB, 32'h11, 32'h000000AA, 0);
        checks++; if (done_cyc !== 3 || n_done !== 1) begin failures++; $display("FAIL sb_done got=%0d/%0d exp=3/1", done_cyc, n_done); end
        checks++; if (memwr_mask !== 6'b000010) begin failures++; $display("FAIL sb_memwr got=%b exp=000010", memwr_mask); end
        checks++; if (busy_mask !== 6'b000111) begin failures++; $display("FAIL sb_busy got=%b exp=000111", busy_mask); end
        checks++; if (mem[4] !== 32'h11AA3344) begin failures++; $display("FAIL sb_mem got=%h exp=11aa3344", mem[4]); end
        issue(OP_LB, 32'h11, 32'h0, 0);
        checks++; if (bus.rdata !== 32'hFFFFFFAA) begin failures++; $display("FAIL lb_rdata got=%h exp=ffffffaa", bus.rdata); end
        issue(OP_LBU, 32'h11, 32'h0, 0);
        checks++; if (bus.rdata !== 32'h000000AA) begin failures++; $display("FAIL lbu_rdata got=%h exp=000000aa", bus.rdata); end
    endtask

    task automatic test_half();
        issue(OP_SH, 32'h12, 32'h0000BEEF, 0);
        checks++; if (done_cyc !== 3 || n_done !== 1) begin failures++; $display("FAIL sh_done got=%0d/%0d exp=3/1", done_cyc, n_done); end
        checks++; if (memwr_mask !== 6'b000010) begin failures++; $display("FAIL sh_memwr got=%b exp=000010", memwr_mask); end
        checks++; if (mem[4] !== 32'h11AABEEF) begin failures++; $display("FAIL sh_mem got=%h exp=11aabeef", mem[4]); end
        issue(OP_LH, 32'h12, 32'h0, 0);
        checks++; if (bus.rdata !== 32'hFFFFBEEF) begin failures++; $display("FAIL lh_rdata got=%h exp=ffffbeef", bus.rdata); end
        issue(OP_LHU, 32'h12, 32'h0, 0);
        checks++; if (bus.rdata !== 32'h0000BEEF) begin failures++; $display("FAIL lhu_rdata got=%h exp=0000beef", bus.rdata); end
        issue(OP_LH, 32'h10, 32'h0, 0);
        checks++; if (bus.rdata !== 32'h000011AA) begin failures++; $display("FAIL lh0_rdata got=%h exp=000011aa", bus.rdata); end
        issue(OP_LB, 32'h10, 32'h0, 0);
        checks++; if (bus.rdata !== 32'h00000011) begin failures++; $display("FAIL lb0_rdata got=%h exp=00000011", bus.rdata); end
    endtask

    task automatic test_misaligned();
        issue(OP_LW, 32'h13, 32'h0, 0);
        checks++; if (done_cyc !== 1 || err_at_done !== 1'b1) begin failures++; $display("FAIL mis_lw got=cyc%0d err%b exp=cyc1 err1", done_cyc, err_at_done); end
        checks++; if (memwr_mask !== 6'b000000 || busy_mask !== 6'b000001) begin failures++; $display("FAIL mis_lw_bus got=%b/%b exp=000000/000001", memwr_mask, busy_mask); end
        checks++; if (bus.rdata !== 32'h00000011) begin failures++; $display("FAIL mis_lw_rdata got=%h exp=00000011", bus.rdata); end
        issue(OP_SH, 32'h11, 32'h00001234, 0);
        checks++; if (done_cyc !== 1 || err_at_done !== 1'b1) begin failures++; $display("FAIL mis_sh got=cyc%0d err%b exp=cyc1 err1", done_cyc, err_at_done); end
        checks++; if (memwr_mask !== 6'b000000) begin failures++; $display("FAIL mis_sh_memwr got=%b exp=000000", memwr_mask); end
        checks++; if (mem[4] !== 32'h11AABEEF) begin failures++; $display("FAIL mis_sh_mem got=%h exp=11aabeef", mem[4]); end
        issue(OP_SW, 32'h02, 32'hDEADBEEF, 0);
        checks++; if (done_cyc !== 1 || err_at_done !== 1'b1) begin failures++; $display("FAIL mis_sw got=cyc%0d err%b exp=cyc1 err1", done_cyc, err_at_done); end
        checks++; if (memwr_mask !== 6'b000000) begin failures++; $display("FAIL mis_sw_memwr got=%b exp=000000", memwr_mask); end
        checks++; if (mem[0] !== 32'h0) begin failures++; $display("FAIL mis_sw_mem got=%h exp=00000000", mem[0]); end
        checks++; if (bus.rdata !== 32'h00000011) begin failures++; $display("FAIL mis_sw_rdata got=%h exp=00000011", bus.rdata); end
    endtask

    task automatic test_alias();
        issue(OP_LW, 32'h00000410, 32'h0, 0);
        checks++; if (dm_addr_c1 !== 32'h00000410) begin failures++; $display("FAIL alias_dm_addr got=%h exp=00000410", dm_addr_c1); end
        checks++; if (bus.rdata !== 32'h11AABEEF || err_at_done !== 1'b0) begin failures++; $display("FAIL alias_rdata got=%h err%b exp=11aabeef err0", bus.rdata, err_at_done); end
    endtask

    task automatic test_back_to_back();
        issue(OP_LW, 32'h10, 32'h0, 2);
        checks++; if (n_done !== 1 || done_cyc !== 2) begin failures++; $display("FAIL b2b_lw_done got=%0d/%0d exp=1/2", n_done, done_cyc); end
        checks++; if (busy_mask !== 6'b000011) begin failures++; $display("FAIL b2b_lw_busy got=%b exp=000011", busy_mask); end
        issue(OP_SB, 32'h13, 32'h00000077, 3);
        checks++; if (n_done !== 1 || done_cyc !== 3) begin failures++; $display("FAIL b2b_sb_done got=%0d/%0d exp=1/3", n_done, done_cyc); end
        checks++; if (memwr_mask !== 6'b000010 || busy_mask !== 6'b000111) begin failures++; $display("FAIL b2b_sb_bus got=%b/%b exp=000010/000111", memwr_mask, busy_mask); end
        checks++; if (mem[4] !== 32'h11AABE77) begin failures++; $display("FAIL b2b_sb_mem got=%h exp=11aabe77", mem[4]); end
    endtask

    task automatic test_reset_mid();
        int dones;
        int writes;
        dones = 0; writes = 0;
        bus.req = 1'b1; bus.op = OP_SB; bus.addr = 32'h10; bus.wdata = 32'h00000055;
        @(posedge clk); #1;
        bus.req = 1'b0; rst = 1'b1;
        @(negedge clk);
        checks++; if (bus.busy !== 1'b1 || bus.dm_memwr !== 1'b0) begin failures++; $display("FAIL rmid_rd got=busy%b wr%b exp=busy1 wr0", bus.busy, bus.dm_memwr); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rmid_idle got=%b exp=0", bus.busy); end
        for (int c = 0; c < 4; c++) begin
            if (bus.done === 1'b1) dones++;
            if (bus.dm_memwr === 1'b1) writes++;
            @(negedge clk);
        end
        checks++; if (dones !== 0 || writes !== 0) begin failures++; $display("FAIL rmid_quiet got=done%0d wr%0d exp=0/0", dones, writes); end
        checks++; if (mem[4] !== 32'h11AABE77) begin failures++; $display("FAIL rmid_mem got=%h exp=11aabe77", mem[4]); end
        checks++; if (bus.rdata !== 32'h0) begin failures++; $display("FAIL rmid_rdata got=%h exp=0", bus.rdata); end
    endtask

    initial begin
        checks = 0; failures = 0;
        rst = 1'b1; dm_clear = 1'b1;
        bus.req = 1'b0; bus.op = OP_LW; bus.addr = '0; bus.wdata = '0;
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_misaligned();
        test_alias();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
